tail_light_dim_ctrl: RTL and testbench

- Sequences the 8-bit duty_cycle that drives one free-running 8-bit PWM stage of a tail light.
- Resolves lights/brake/hazard requests into a target brightness and ramps duty toward that target.
- Applies every duty change only on a PWM period boundary, so no period is truncated or glitched.
- Sits between the vehicle-input synchronisers and the PWM instance; one controller per lamp.

---
 rtl/tail_light_dim_ctrl_if.sv | 20 ++
 rtl/tail_light_dim_ctrl.sv | 143 ++++++++++++++
 tb/tb_tail_light_dim_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tail_light_dim_ctrl_if.sv
// Tail-light controller signal bundle: vehicle requests in, PWM duty/debug out.
// master = the side driving the vehicle requests; slave = the controller.
interface tail_light_dim_ctrl_if;
  logic       lights_on;
  logic       brake;
  logic       hazard;
  logic [7:0] duty_cycle;
  logic       period_start;
  logic [2:0] state;

  modport master (
    output lights_on, brake, hazard,
    input  duty_cycle, period_start, state
  );

  modport slave (
    input  lights_on, brake, hazard,
    output duty_cycle, period_start, state
  );
endinterface

// File: rtl/tail_light_dim_ctrl.sv
// Tail-light duty sequencer for one free-running 8-bit PWM stage.
// Resolves brake/hazard/lights requests into a target brightness, ramps toward it
// and only updates duty on the cycle after a PWM period boundary.
// Optional macro TAIL_HAZARD_EN: adds the hazard blinker (HAZ_ON/HAZ_OFF states and
// blink counter). Without it the hazard input is ignored.
module tail_light_dim_ctrl #(
  parameter logic [7:0]  DIM_LEVEL     = 8'd32,
  parameter logic [7:0]  FULL_LEVEL    = 8'd255,
  parameter logic [7:0]  STEP          = 8'd8,
  parameter int unsigned RAMP_DIV      = 4,
  parameter int unsigned BLINK_PERIODS = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tail_light_dim_ctrl_if.slave bus
);

  localparam int unsigned   RW        = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_DIM     = 3'd1,
    ST_BRAKE   = 3'd2,
    ST_HAZ_ON  = 3'd3,
    ST_HAZ_OFF = 3'd4,
    ST_FADE    = 3'd5
  } state_t;

  logic [7:0]    cnt_q;
  logic          period_start_q;
  state_t        state_q, state_d;
  logic [7:0]    duty_q, duty_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [7:0]    target;
  state_t        rest_state;

`ifdef TAIL_HAZARD_EN
  localparam int unsigned   BW         = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIODS - 1);

  logic [BW-1:0] blink_q, blink_d;
  logic          phase_on_q, phase_on_d;
  logic          haz_prev_q, haz_prev_d;
`else
  logic          unused_hazard;
  assign unused_hazard = bus.hazard;
`endif

  // Next-state decision: everything holds except on the cycle period_start is high.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    ramp_d     = ramp_q;
    target     = bus.lights_on ? DIM_LEVEL : 8'd0;
    rest_state = bus.lights_on ? ST_DIM : ST_OFF;
`ifdef TAIL_HAZARD_EN
    blink_d    = blink_q;
    phase_on_d = phase_on_q;
    haz_prev_d = haz_prev_q;
`endif
    if (period_start_q) begin
`ifdef TAIL_HAZARD_EN
      // A fresh hazard request restarts the blinker in the on phase; brake freezes it.
      haz_prev_d = bus.hazard;
      if (bus.hazard && !haz_prev_q) begin
        blink_d    = '0;
        phase_on_d = 1'b1;
      end else if (bus.hazard && !bus.brake) begin
        if (blink_q == BLINK_LAST) begin
          blink_d    = '0;
          phase_on_d = !phase_on_q;
        end else begin
          blink_d = blink_q + BW'(1);
        end
      end
`endif
      if (bus.brake) begin
        // Brake is safety-critical: jump straight to full, no ramp.
        duty_d  = FULL_LEVEL;
        state_d = ST_BRAKE;
      end
`ifdef TAIL_HAZARD_EN
      else if (bus.hazard) begin
        duty_d  = phase_on_d ? FULL_LEVEL : 8'd0;
        state_d = phase_on_d ? ST_HAZ_ON : ST_HAZ_OFF;
      end
`endif
      else if (duty_q == target) begin
        state_d = rest_state;
      end else begin
        // Fade: the ramp counter keeps running across target changes so a
        // reversal continues from the current duty on the same cadence.
        state_d = ST_FADE;
        if (ramp_q == RAMP_LAST) begin
          ramp_d = '0;
          if (target > duty_q) begin
            duty_d = ((target - duty_q) <= STEP) ? target : duty_q + STEP;
          end else begin
            duty_d = ((duty_q - target) <= STEP) ? target : duty_q - STEP;
          end
          if (duty_d == target) begin
            state_d = rest_state;
          end
        end else begin
          ramp_d = ramp_q + RW'(1);
        end
      end
    end
  end

  // State, duty and period registers with asynchronous return to the dark state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= 8'd0;
      period_start_q <= 1'b0;
      state_q        <= ST_OFF;
      duty_q         <= 8'd0;
      ramp_q         <= '0;
`ifdef TAIL_HAZARD_EN
      blink_q        <= '0;
      phase_on_q     <= 1'b1;
      haz_prev_q     <= 1'b0;
`endif
    end else begin
      cnt_q          <= cnt_q + 8'd1;
      period_start_q <= (cnt_q == 8'd0);
      state_q        <= state_d;
      duty_q         <= duty_d;
      ramp_q         <= ramp_d;
`ifdef TAIL_HAZARD_EN
      blink_q        <= blink_d;
      phase_on_q     <= phase_on_d;
      haz_prev_q     <= haz_prev_d;
`endif
    end
  end

  assign bus.duty_cycle   = duty_q;
  assign bus.period_start = period_start_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_tail_light_dim_ctrl.sv
// Bench for tail_light_dim_ctrl: vector table, hand-written corner sequences,
// random stimulus, and a per-cycle comparison against a boundary-level model.
// The blink half-cycle is shortened to 16 periods to keep the run short.
module tb_tail_light_dim_ctrl;

  localparam int DIM   = 32;
  localparam int FULL  = 255;
  localparam int STEP  = 8;
  localparam int RAMP  = 4;
  localparam int BLINK = 16;
`ifdef TAIL_HAZARD_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  tail_light_dim_ctrl_if bif ();

  tail_light_dim_ctrl #(
    .BLINK_PERIODS(BLINK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // k: clock edges since reset; a boundary is processed on the edge after
  // period_start, and period_start follows edges 1, 257, 513, ...
  // fade_n counts fade boundaries (a step every RAMP of them); haz_n counts
  // blinking boundaries since the hazard request began (phase = haz_n/BLINK parity).
  typedef struct {
    int k;
    bit ps;
    int duty;
    int st;
    int fade_n;
    int haz_n;
    bit haz_prev;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t cur, bit l, bit b, bit h);
    model_t nx;
    int     target;
    int     rest;
    int     diff;
    nx = cur;
    nx.k  = cur.k + 1;
    nx.ps = ((nx.k - 1) % 256) == 0;
    if (!HAZ_EN) h = 1'b0;
    if (cur.ps) begin
      if (h && !cur.haz_prev) nx.haz_n = 0;
      else if (h && !b)       nx.haz_n = cur.haz_n + 1;
      nx.haz_prev = h;
      if (b) begin
        nx.duty = FULL;
        nx.st   = 2;
      end else if (h) begin
        if (((nx.haz_n / BLINK) % 2) == 0) begin
          nx.duty = FULL;
          nx.st   = 3;
        end else begin
          nx.duty = 0;
          nx.st   = 4;
        end
      end else begin
        target = l ? DIM : 0;
        rest   = l ? 1 : 0;
        if (cur.duty == target) begin
          nx.st = rest;
        end else begin
          nx.fade_n = cur.fade_n + 1;
          nx.st     = 5;
          if ((nx.fade_n % RAMP) == 0) begin
            diff = target - cur.duty;
            if (diff > STEP)       nx.duty = cur.duty + STEP;
            else if (diff < -STEP) nx.duty = cur.duty - STEP;
            else                   nx.duty = target;
            if (nx.duty == target) nx.st = rest;
          end
        end
      end
    end
    return nx;
  endfunction

  // Advance the model on every DUT clock edge; reset it alongside the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= model_step(m, bif.lights_on, bif.brake, bif.hazard);
  end

  // Per-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      n_checks++;
      if (bif.duty_cycle === 8'(m.duty) && bif.state === 3'(m.st) &&
          bif.period_start === m.ps)
        n_pass++;
      else
        $display("FAIL cycle t=%0t: duty=%0d exp %0d, state=%0d exp %0d, period_start=%0d exp %0d",
                 $time, bif.duty_cycle, m.duty, bif.state, m.st, bif.period_start, m.ps);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    int l;
    int b;
    int h;
    int n;
    int duty;
    int st;
  } vec_t;

  task automatic do_reset();
    rst_n          = 1'b0;
    bif.lights_on  = 1'b0;
    bif.brake      = 1'b0;
    bif.hazard     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait at negedges until period_start is seen, bounded.
  task automatic wait_ps(output bit ok);
    int guard;
    guard = 0;
    while (bif.period_start !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    ok = (guard < 300);
    if (!ok) begin
      n_checks++;
      $display("FAIL boundary_timeout: no period_start within %0d cycles, required within 257", guard);
    end
  endtask

  // Pass n boundaries; returns at the negedge where the last duty update is visible.
  task automatic wait_bnd(int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      wait_ps(ok);
      if (!ok) return;
      @(negedge clk);
    end
  endtask

  task automatic apply_row(string tag, int idx, vec_t v);
    bif.lights_on = v.l[0];
    bif.brake     = v.b[0];
    bif.hazard    = v.h[0];
    wait_bnd(v.n);
    $display("%s %0d: L=%0d B=%0d H=%0d after %0d periods -> duty=%0d state=%0d",
             tag, idx, v.l, v.b, v.h, v.n, bif.duty_cycle, bif.state);
    check($sformatf("%s%0d_duty", tag, idx), bif.duty_cycle, v.duty);
    check($sformatf("%s%0d_state", tag, idx), bif.state, v.st);
  endtask

  vec_t tab[16];
  vec_t haz_tab[9];

  initial begin
    bit ok;

    tab = '{
      '{1, 0, 0,   1,   0, 5},
      '{1, 0, 0,   3,   8, 5},
      '{1, 0, 0,   4,  16, 5},
      '{1, 0, 0,   4,  24, 5},
      '{1, 0, 0,   4,  32, 1},
      '{1, 0, 0,   8,  32, 1},
      '{1, 1, 0,   1, 255, 2},
      '{1, 0, 0,   4, 247, 5},
      '{1, 0, 0, 104,  39, 5},
      '{1, 0, 0,   4,  32, 1},
      '{0, 0, 0,  16,   0, 0},
      '{0, 0, 0,   2,   0, 0},
      '{1, 0, 0,   8,  16, 5},
      '{0, 0, 0,   4,   8, 5},
      '{0, 0, 0,   4,   0, 0},
      '{0, 0, 0,   4,   0, 0}
    };
    haz_tab = '{
      '{0, 0, 1,  1, 255, 3},
      '{0, 0, 1, 15, 255, 3},
      '{0, 0, 1,  1,   0, 4},
      '{0, 0, 1,  5,   0, 4},
      '{0, 1, 1,  3, 255, 2},
      '{0, 0, 1,  1,   0, 4},
      '{0, 0, 1,  9,   0, 4},
      '{0, 0, 1,  1, 255, 3},
      '{1, 0, 0,  1, 255, 5}
    };

    #1;
    do_reset();
    check("reset_duty", bif.duty_cycle, 0);
    check("reset_state", bif.state, 0);
    check("reset_period_start", bif.period_start, 0);

    // Ramp up to DIM and settle.
    for (int i = 0; i < 6; i++) apply_row("row", i, tab[i]);

    // Brake pressed mid-period: duty must jump exactly one clk after period_start.
    repeat (100) @(negedge clk);
    bif.brake = 1'b1;
    wait_ps(ok);
    check("brake_before_update", bif.duty_cycle, 32);
    @(negedge clk);
    check("brake_latency_duty", bif.duty_cycle, 255);
    check("brake_latency_state", bif.state, 2);
    $display("brake pulse: duty=%0d state=%0d one clk after period_start", bif.duty_cycle, bif.state);

    // Brake held, released into clamped fade, lights reversal mid-ramp.
    for (int i = 6; i < 16; i++) apply_row("row", i, tab[i]);

    // Reset in the middle of a fade clears outputs before the next clock edge.
    bif.brake = 1'b1;
    wait_bnd(1);
    bif.brake = 1'b0;
    wait_bnd(8);
    check("prefade_duty", bif.duty_cycle, 239);
    check("prefade_state", bif.state, 5);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_duty", bif.duty_cycle, 0);
    check("async_reset_state", bif.state, 0);
    check("async_reset_period_start", bif.period_start, 0);
    $display("async reset mid-fade: duty=%0d state=%0d", bif.duty_cycle, bif.state);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random requests changing at arbitrary points within the period.
    for (int t = 0; t < 20; t++) begin
      bif.lights_on = 1'($urandom_range(0, 1));
      bif.brake     = ($urandom_range(0, 3) == 0);
      bif.hazard    = HAZ_EN && ($urandom_range(0, 2) == 0);
      repeat ($urandom_range(40, 600)) @(negedge clk);
      $display("rand %0d: L=%0d B=%0d H=%0d -> duty=%0d state=%0d",
               t, bif.lights_on, bif.brake, bif.hazard, bif.duty_cycle, bif.state);
    end

    // Hazard blinking, brake freeze during the off phase, resume, release.
    if (HAZ_EN) begin
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 9; i++) apply_row("haz", i, haz_tab[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
